// File: rtl/soc_pio_pkg.sv
// Shared register map and field positions for the input PIO slave.
package soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_LED  = 2'd3;

  localparam int KEY_CLEAR_BIT = 0;
  localparam int KEY_ACC_BIT   = 1;

  localparam int DATA_SW_LSB    = 0;
  localparam int DATA_CLEAR_BIT = 8;
  localparam int DATA_ACC_BIT   = 9;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchroniser, stability counter, debounced level and rise pulse.
module debounce_bit
  import soc_pio_pkg::*;
#(
  parameter bit          RESET_VAL       = 1'b0,
  parameter bit          INVERT          = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             synced;
  logic [CNT_W-1:0] cnt;

  // Inversion happens after the synchroniser so level is always "asserted = 1".
  assign synced = sync2 ^ INVERT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      level <= RESET_VAL ^ INVERT;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= synced;
        rise  <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_input_pio_slave.sv
// Avalon-MM slave: debounced switches/keys, key-press edge capture with maskable IRQ, LED register.
module soc_input_pio_slave
  import soc_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int          SW_W            = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      address,
  input  logic            read,
  input  logic            write,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic            irq,
  input  logic [SW_W-1:0] sw_in,
  input  logic            key_clear_n,
  input  logic            key_acc_n,
  output logic [SW_W-1:0] led_out
);

  logic [SW_W-1:0] sw_db;
  logic [SW_W-1:0] sw_rise_unused;
  logic [1:0]      key_raw;
  logic [1:0]      key_db;
  logic [1:0]      key_rise;
  logic [1:0]      edge_q;
  logic [1:0]      mask_q;
  logic [1:0]      edge_w1c;
  logic [31:0]     rd_mux;
  logic            unused_wdata;

  assign key_raw[KEY_CLEAR_BIT] = key_clear_n;
  assign key_raw[KEY_ACC_BIT]   = key_acc_n;
  assign unused_wdata           = ^writedata[31:SW_W];

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    debounce_bit #(
      .RESET_VAL      (1'b0),
      .INVERT         (1'b0),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sw_in[i]),
      .level  (sw_db[i]),
      .rise   (sw_rise_unused[i])
    );
  end

  // Keys idle high; preset to released so reset release never looks like a press.
  for (genvar k = 0; k < 2; k++) begin : g_key
    debounce_bit #(
      .RESET_VAL      (1'b1),
      .INVERT         (1'b1),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (key_raw[k]),
      .level  (key_db[k]),
      .rise   (key_rise[k])
    );
  end

  assign edge_w1c = (write && address == ADDR_EDGE) ? writedata[1:0] : 2'b00;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: begin
        rd_mux[DATA_SW_LSB +: SW_W] = sw_db;
        rd_mux[DATA_CLEAR_BIT]      = key_db[KEY_CLEAR_BIT];
        rd_mux[DATA_ACC_BIT]        = key_db[KEY_ACC_BIT];
      end
      ADDR_EDGE: rd_mux[1:0]      = edge_q;
      ADDR_MASK: rd_mux[1:0]      = mask_q;
      ADDR_LED:  rd_mux[SW_W-1:0] = led_out;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      led_out  <= '0;
      irq      <= 1'b0;
    end else begin
      if (read) readdata <= rd_mux;
      // A new press in the same cycle as its W1C keeps the bit set.
      edge_q <= (edge_q & ~edge_w1c) | key_rise;
      if (write && address == ADDR_MASK) mask_q  <= writedata[1:0];
      if (write && address == ADDR_LED)  led_out <= writedata[SW_W-1:0];
      irq <= |(edge_q & mask_q);
    end
  end

endmodule

// File: tb/tb_soc_input_pio_slave.sv
// Scoreboard bench for soc_input_pio_slave with a short debounce window.
module tb_soc_input_pio_slave;
  import soc_pio_pkg::*;

  localparam int SW_W = 8;
  localparam int DB   = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      address = '0;
  logic            read = 1'b0;
  logic            write = 1'b0;
  logic [31:0]     writedata = '0;
  logic [31:0]     readdata;
  logic            irq;
  logic [SW_W-1:0] sw_in = '0;
  logic            key_clear_n = 1'b1;
  logic            key_acc_n = 1'b1;
  logic [SW_W-1:0] led_out;

  soc_input_pio_slave #(.DEBOUNCE_CYCLES(DB), .SW_W(SW_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .sw_in      (sw_in),
    .key_clear_n(key_clear_n),
    .key_acc_n  (key_acc_n),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic rd_d   = 1'b0;

  always @(posedge clk) rd_d <= read;

  // Monitor: a read strobe seen at a clock edge means readdata is valid now.
  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_read got=0x%0h with empty scoreboard", readdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (readdata !== e.value) begin
          n_fail++;
          $display("FAIL %s got=0x%0h exp=0x%0h", e.name, readdata, e.value);
        end
      end
    end
  end

  task automatic check_pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    address = a;
    read    = 1'b1;
    e.name  = name;
    e.value = exp;
    exp_q.push_back(e);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(3);
    check_pin("reset_irq", {31'd0, irq}, 32'd0);
    check_pin("reset_led", {24'd0, led_out}, 32'd0);
    check_pin("reset_readdata", readdata, 32'd0);
    reset_n = 1'b1;

    // 1. reset values
    do_read(ADDR_DATA, 32'h0, "rst_data");
    do_read(ADDR_EDGE, 32'h0, "rst_edge");
    do_read(ADDR_MASK, 32'h0, "rst_mask");
    do_read(ADDR_LED,  32'h0, "rst_led");

    // 2. switches and a short glitch
    sw_in = 8'hA5;
    wait_cyc(10);
    do_read(ADDR_DATA, 32'h0A5, "sw_a5");
    sw_in = 8'hA4;
    wait_cyc(2);
    sw_in = 8'hA5;
    wait_cyc(10);
    do_read(ADDR_DATA, 32'h0A5, "sw_glitch");

    // 3. acc press, mask, irq, W1C
    key_acc_n = 1'b0;
    wait_cyc(10);
    do_read(ADDR_DATA, 32'h2A5, "acc_data");
    do_read(ADDR_EDGE, 32'h2, "acc_edge");
    do_write(ADDR_MASK, 32'h2);
    check_pin("irq_before", {31'd0, irq}, 32'd0);
    wait_cyc(1);
    check_pin("irq_set", {31'd0, irq}, 32'd1);
    do_write(ADDR_EDGE, 32'h2);
    check_pin("irq_hold", {31'd0, irq}, 32'd1);
    wait_cyc(1);
    check_pin("irq_clr", {31'd0, irq}, 32'd0);
    key_acc_n = 1'b1;
    wait_cyc(10);
    do_read(ADDR_EDGE, 32'h0, "acc_release_no_edge");
    do_write(ADDR_EDGE, 32'h2);
    do_read(ADDR_EDGE, 32'h0, "w1c_zero_bit");

    // 4. W1C lands in the same cycle the clear press sets EDGE[0]
    @(negedge clk);
    key_clear_n = 1'b0;
    wait_cyc(5);
    do_write(ADDR_EDGE, 32'h1);
    do_read(ADDR_EDGE, 32'h1, "set_beats_w1c");
    do_read(ADDR_DATA, 32'h1A5, "clear_data");
    check_pin("irq_masked", {31'd0, irq}, 32'd0);
    do_write(ADDR_EDGE, 32'h1);
    do_read(ADDR_EDGE, 32'h0, "w1c_clear");
    key_clear_n = 1'b1;
    wait_cyc(10);

    // 5. LED register, DATA is read-only, read+write same address
    do_write(ADDR_LED, 32'h3C);
    check_pin("led_out", {24'd0, led_out}, 32'h3C);
    do_read(ADDR_LED, 32'h3C, "led_read");
    do_write(ADDR_DATA, 32'hFFFF);
    do_read(ADDR_DATA, 32'h0A5, "data_ro");
    begin
      exp_t e;
      @(negedge clk);
      address   = ADDR_MASK;
      writedata = 32'hFFFF_FFFF;
      write     = 1'b1;
      read      = 1'b1;
      e.name    = "rw_pre_value";
      e.value   = 32'h2;
      exp_q.push_back(e);
      @(negedge clk);
      write = 1'b0;
      read  = 1'b0;
    end
    do_read(ADDR_MASK, 32'h3, "mask_unused_bits");

    // 6. reset in the middle of a clear debounce
    @(negedge clk);
    key_clear_n = 1'b0;
    wait_cyc(3);
    reset_n = 1'b0;
    wait_cyc(2);
    check_pin("midrst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    // key still low: sync at edge k, level at k+5, EDGE at k+6, visible to a read at k+7
    for (int j = 1; j <= 8; j++) begin
      exp_t e;
      @(negedge clk);
      address = ADDR_EDGE;
      read    = 1'b1;
      e.name  = $sformatf("midrst_edge_c%0d", j);
      e.value = (j >= 7) ? 32'h1 : 32'h0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    read = 1'b0;
    key_clear_n = 1'b1;

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    wait_cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
